// File: rtl/alu_ex_stage.sv
// alu_ex_stage: execute stage behind the ALU control decoder.
// Computes the ALU result and captures it with the zero flag, an illegal-op flag and the
// destination tag in a one-entry EX/MEM register, with a valid/ready handshake on both sides.
// Optional feature: define ALU_EX_OVERFLOW_EN to add the registered out_overflow port
// (signed overflow for ADD and SUB).
module alu_ex_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RD_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_operation,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [RD_W-1:0]  in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_illegal,
    output logic [RD_W-1:0]  out_rd
`ifdef ALU_EX_OVERFLOW_EN
    ,
    output logic             out_overflow
`endif
);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0110;
    localparam logic [3:0] OpSlt = 4'b0111;
    localparam logic [3:0] OpNor = 4'b1100;

    typedef enum logic {
        StEmpty,
        StFull
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_illegal;
    logic [RD_W-1:0]  r_rd;

    logic             w_accept;
    logic             w_pop;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_lt;
    logic [WIDTH-1:0] w_result;
    logic             w_illegal;
    logic             w_zero;

    // Ready passes out_ready straight through so a full register can be replaced in one cycle
    assign in_ready  = (r_state == StEmpty) || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == StFull);
    assign w_pop     = out_valid && out_ready;

    assign out_result  = r_result;
    assign out_zero    = r_zero;
    assign out_illegal = r_illegal;
    assign out_rd      = r_rd;

    // ALU datapath: result and illegal-op decode for the offered operation
    always_comb begin
        w_sum     = in_a + in_b;
        w_diff    = in_a - in_b;
        w_lt      = $signed(in_a) < $signed(in_b);
        w_result  = '0;
        w_illegal = 1'b0;
        case (in_operation)
            OpAnd:   w_result = in_a & in_b;
            OpOr:    w_result = in_a | in_b;
            OpAdd:   w_result = w_sum;
            OpSub:   w_result = w_diff;
            OpSlt:   w_result = {{(WIDTH-1){1'b0}}, w_lt};
            OpNor:   w_result = ~(in_a | in_b);
            default: w_illegal = 1'b1;
        endcase
        w_zero = (w_result == '0);
    end

`ifdef ALU_EX_OVERFLOW_EN
    logic w_overflow;
    logic r_overflow;

    assign out_overflow = r_overflow;

    // Signed overflow: ADD with like-signed operands, SUB with unlike-signed operands
    always_comb begin
        w_overflow = 1'b0;
        if (in_operation == OpAdd) begin
            w_overflow = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (w_sum[WIDTH-1] != in_a[WIDTH-1]);
        end else if (in_operation == OpSub) begin
            w_overflow = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (w_diff[WIDTH-1] != in_a[WIDTH-1]);
        end
    end

    // Overflow flag loads alongside the result register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (!flush && w_accept) begin
            r_overflow <= w_overflow;
        end
    end
`endif

    // Handshake FSM and output register; reset beats flush, flush beats accept/pop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StEmpty;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
            r_rd      <= '0;
        end else if (flush) begin
            // Data fields keep stale values; only validity is dropped
            r_state <= StEmpty;
        end else if (w_accept) begin
            r_state   <= StFull;
            r_result  <= w_result;
            r_zero    <= w_zero;
            r_illegal <= w_illegal;
            r_rd      <= in_rd;
        end else if (w_pop) begin
            r_state <= StEmpty;
        end
    end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Scoreboard bench for alu_ex_stage: the driver pushes hand-computed expectations when an op
// is accepted, the monitor pops and compares whenever the DUT hands a result downstream.
// Define ALU_EX_OVERFLOW_EN to also cover out_overflow.
module tb_alu_ex_stage;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        logic [4:0]  rd;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_operation;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_illegal;
    logic [4:0]  out_rd;
`ifdef ALU_EX_OVERFLOW_EN
    logic        out_overflow;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    alu_ex_stage #(
        .WIDTH(32),
        .RD_W (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_operation(in_operation),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_illegal (out_illegal),
        .out_rd      (out_rd)
`ifdef ALU_EX_OVERFLOW_EN
        ,
        .out_overflow(out_overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: a result leaves the stage at the edge following a negedge with valid && ready
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1 && reset === 1'b0) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output got %h want none", out_result);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("mon_result", out_result, e.res);
                chk("mon_zero", {31'd0, out_zero}, {31'd0, e.zero});
                chk("mon_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
                chk("mon_rd", {27'd0, out_rd}, {27'd0, e.rd});
`ifdef ALU_EX_OVERFLOW_EN
                chk("mon_overflow", {31'd0, out_overflow}, {31'd0, e.ovf});
`endif
            end
        end
    end

    // Offer one op from posedge+2 until accepted; returns at posedge+2 with in_valid low
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] er, input logic eill,
                        input logic eovf, output int waited);
        logic done;
        done         = 1'b0;
        waited       = 0;
        in_valid     = 1'b1;
        in_operation = op;
        in_a         = a;
        in_b         = b;
        in_rd        = rd;
        while (!done && waited < 20) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                q.push_back('{res: er, zero: (er == 32'd0), ill: eill, rd: rd, ovf: eovf});
                done = 1'b1;
            end
            @(posedge clk);
            #2;
            if (!done) waited++;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got waited=%0d want accept", waited);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int w;
        reset        = 1'b1;
        flush        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        in_operation = 4'd0;
        in_a         = '0;
        in_b         = '0;
        in_rd        = '0;
        idle(2);

        // Reset state
        @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_zero", {31'd0, out_zero}, 32'd0);
        chk("rst_illegal", {31'd0, out_illegal}, 32'd0);
        chk("rst_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #2;
        reset     = 1'b0;
        out_ready = 1'b1;

        // ADD 5+7, one-edge latency
        send(4'b0010, 32'd5, 32'd7, 5'd1, 32'd12, 1'b0, 1'b0, w);
        chk("add_latency_valid", {31'd0, out_valid}, 32'd1);
        chk("add_result_direct", out_result, 32'd12);

        // Back-to-back SUB 9-9 then SLT -1<1, no bubble
        send(4'b0110, 32'd9, 32'd9, 5'd2, 32'd0, 1'b0, 1'b0, w);
        chk("b2b_wait_sub", w, 32'd0);
        send(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd3, 32'd1, 1'b0, 1'b0, w);
        chk("b2b_wait_slt", w, 32'd0);
        idle(2);

        // Stall: AND held while an OR is offered for three cycles
        send(4'b0000, 32'h0000_F0F0, 32'h0000_0FF0, 5'd4, 32'h0000_00F0, 1'b0, 1'b0, w);
        out_ready    = 1'b0;
        in_valid     = 1'b1;
        in_operation = 4'b0001;
        in_a         = 32'h0000_F0F0;
        in_b         = 32'h0000_0FF0;
        in_rd        = 5'd5;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_hold_result", out_result, 32'h0000_00F0);
            chk("stall_hold_rd", {27'd0, out_rd}, 32'd4);
            @(posedge clk);
            #2;
        end
        out_ready = 1'b1;
        send(4'b0001, 32'h0000_F0F0, 32'h0000_0FF0, 5'd5, 32'h0000_FFF0, 1'b0, 1'b0, w);
        chk("stall_release_wait", w, 32'd0);

        // Illegal code, NOR, signed SLT corner, SUB wrap
        send(4'b0101, 32'd3, 32'd4, 5'd6, 32'd0, 1'b1, 1'b0, w);
        send(4'b1100, 32'd0, 32'd0, 5'd7, 32'hFFFF_FFFF, 1'b0, 1'b0, w);
        send(4'b0111, 32'd1, 32'hFFFF_FFFF, 5'd8, 32'd0, 1'b0, 1'b0, w);
        send(4'b0111, 32'd3, 32'd5, 5'd9, 32'd1, 1'b0, 1'b0, w);
        send(4'b0110, 32'd3, 32'd5, 5'd10, 32'hFFFF_FFFE, 1'b0, 1'b0, w);
        send(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd11, 32'd0, 1'b0, 1'b0, w);
`ifdef ALU_EX_OVERFLOW_EN
        send(4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd12, 32'h8000_0000, 1'b0, 1'b1, w);
        send(4'b0110, 32'h8000_0000, 32'd1, 5'd13, 32'h7FFF_FFFF, 1'b0, 1'b1, w);
        send(4'b0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd14, 32'h8000_0000, 1'b0, 1'b0, w);
`endif
        idle(2);

        // Flush in FULL: held ADD is handed off, the op offered alongside flush is dropped
        out_ready = 1'b0;
        send(4'b0010, 32'd1, 32'd1, 5'd15, 32'd2, 1'b0, 1'b0, w);
        out_ready    = 1'b1;
        flush        = 1'b1;
        in_valid     = 1'b1;
        in_operation = 4'b0010;
        in_a         = 32'd100;
        in_b         = 32'd100;
        in_rd        = 5'd16;
        @(posedge clk);
        #2;
        flush    = 1'b0;
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("flush_valid_low", {31'd0, out_valid}, 32'd0);
            @(posedge clk);
            #2;
        end

        // Reset during a stall drops the held result
        out_ready = 1'b0;
        send(4'b0001, 32'd1, 32'd2, 5'd17, 32'd3, 1'b0, 1'b0, w);
        reset = 1'b1;
        q.delete();
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("stall_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("stall_rst_result", out_result, 32'd0);
        chk("stall_rst_zero", {31'd0, out_zero}, 32'd0);
        chk("stall_rst_illegal", {31'd0, out_illegal}, 32'd0);
        chk("stall_rst_rd", {27'd0, out_rd}, 32'd0);
`ifdef ALU_EX_OVERFLOW_EN
        chk("stall_rst_overflow", {31'd0, out_overflow}, 32'd0);
`endif
        @(posedge clk);
        #2;

        // Resume after reset
        out_ready = 1'b1;
        send(4'b0010, 32'd20, 32'd22, 5'd18, 32'd42, 1'b0, 1'b0, w);

        // Drain with a bound
        begin
            int n;
            n = 0;
            while (q.size() != 0 && n < 20) begin
                @(posedge clk);
                #2;
                n++;
            end
        end
        chk("queue_drained", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
